// File: rtl/invaders.sv
// Invader formation engine: one row of 20 slots that marches, descends at the edges and resolves bullet hits.
// Formation and hit updates are registered one cycle after inputs; the formation never stalls, only start gates a wave.
module invaders #(
  parameter int MOVE_PERIOD = 25_000_000
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  bullet_x,
  input  logic [3:0]  bullet_y,
  input  logic [2:0]  level,
  output logic        hit,
  output logic [19:0] invaders_array,
  output logic [4:0]  invaders_line
);

  localparam int CW = (MOVE_PERIOD < 2) ? 1 : $clog2(MOVE_PERIOD + 1);
  localparam logic [CW-1:0] MP_V = CW'(MOVE_PERIOD);
  localparam logic [19:0] WAVE = 20'h0AAAA;
  localparam logic [4:0]  LANDED = 5'd16;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_t;

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, w_dir_nxt;
  logic [19:0]   r_arr, w_arr_nxt;
  logic [4:0]    r_line, w_line_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_hit, w_hit_nxt;

  logic [CW-1:0] w_shifted;
  logic [CW-1:0] w_period;
  logic          w_step;
  logic [19:0]   w_mask;
  logic          w_collide;

  assign w_shifted = MP_V >> level;
  assign w_period  = (w_shifted == '0) ? CW'(1) : w_shifted;
  // >= keeps the counter from running past a period shortened by a level change
  assign w_step    = (r_cnt >= w_period - CW'(1));

  // An out-of-range column shifts the mask to zero, so it can never hit
  assign w_mask    = 20'd1 << bullet_x;
  assign w_collide = (r_state == S_RUN) && (r_line < LANDED) &&
                     (bullet_y == r_line[3:0]) && ((r_arr & w_mask) != 20'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_arr_nxt   = r_arr;
    w_line_nxt  = r_line;
    w_cnt_nxt   = r_cnt;
    w_hit_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_arr_nxt   = WAVE;
          w_line_nxt  = 5'd0;
          w_dir_nxt   = DIR_RIGHT;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (w_collide) begin
          w_arr_nxt = r_arr & ~w_mask;
          w_hit_nxt = 1'b1;
        end
        // The step sees the array with this cycle's kill already removed
        if (w_step) begin
          w_cnt_nxt = '0;
          if (r_dir == DIR_RIGHT) begin
            if (!w_arr_nxt[19]) begin
              w_arr_nxt = w_arr_nxt << 1;
            end else begin
              w_line_nxt = r_line + 5'd1;
              w_dir_nxt  = DIR_LEFT;
            end
          end else begin
            if (!w_arr_nxt[0]) begin
              w_arr_nxt = w_arr_nxt >> 1;
            end else begin
              w_line_nxt = r_line + 5'd1;
              w_dir_nxt  = DIR_RIGHT;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        if ((w_arr_nxt == 20'd0) || (w_line_nxt == LANDED)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dir   <= DIR_RIGHT;
      r_arr   <= 20'd0;
      r_line  <= 5'd0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_arr   <= w_arr_nxt;
      r_line  <= w_line_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hit   <= w_hit_nxt;
    end
  end

  assign hit            = r_hit;
  assign invaders_array = r_arr;
  assign invaders_line  = r_line;

endmodule

// File: tb/tb_invaders.sv
// Randomized bench for invaders with a slot-level game model; MOVE_PERIOD=8 so levels 0..3 give periods 8,4,2,1.
module tb_invaders;
  localparam int MP = 8;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic [2:0]  level;
  logic        hit;
  logic [19:0] invaders_array;
  logic [4:0]  invaders_line;

  int checks = 0;
  int errors = 0;

  invaders #(.MOVE_PERIOD(MP)) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .start(start),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .level(level),
    .hit(hit), .invaders_array(invaders_array), .invaders_line(invaders_line)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  // Game model: per-slot alive flags, line number, heading, tick count
  bit m_alive[20];
  int m_line;
  bit m_left;
  int m_cnt;
  bit m_run;
  bit m_hit;

  function automatic logic [19:0] m_arr();
    logic [19:0] v = '0;
    for (int c = 0; c < 20; c++) v[c] = m_alive[c];
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int c = 0; c < 20; c++) n += m_alive[c];
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 20; c++) m_alive[c] = 1'b0;
    m_line = 0; m_left = 0; m_cnt = 0; m_run = 0; m_hit = 0;
  endtask

  task automatic model_tick();
    int p;
    m_hit = 0;
    if (!m_run) begin
      if (start) begin
        for (int c = 0; c < 20; c++) m_alive[c] = (c % 2 == 1) && (c <= 15);
        m_line = 0; m_left = 0; m_cnt = 0; m_run = 1;
      end
    end else begin
      p = MP >> level;
      if (p < 1) p = 1;
      if (m_line < 16 && bullet_x < 20 && int'(bullet_y) == m_line && m_alive[bullet_x]) begin
        m_alive[bullet_x] = 0;
        m_hit = 1;
      end
      if (m_cnt >= p - 1) begin
        m_cnt = 0;
        if (!m_left) begin
          if (!m_alive[19]) begin
            for (int c = 19; c > 0; c--) m_alive[c] = m_alive[c-1];
            m_alive[0] = 0;
          end else begin m_line++; m_left = 1; end
        end else begin
          if (!m_alive[0]) begin
            for (int c = 0; c < 19; c++) m_alive[c] = m_alive[c+1];
            m_alive[19] = 0;
          end else begin m_line++; m_left = 0; end
        end
      end else begin
        m_cnt++;
      end
      if (m_count() == 0 || m_line == 16) m_run = 0;
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; bullet_x = 5'd31; bullet_y = 4'd0; level = 3'd0;
    #12;
    checks++;
    if (invaders_array !== 20'd0 || invaders_line !== 5'd0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: arr=%h line=%0d hit=%b want 0 0 0", invaders_array, invaders_line, hit);
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 1000; i++) begin
      bullet_x = 5'($urandom_range(0, 31));
      bullet_y = 4'($urandom_range(0, 15));
      level    = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (invaders_array !== 20'd0 || invaders_line !== 5'd0 || hit !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc %0d: arr=%h line=%0d hit=%b want 0 0 0", i, invaders_array, invaders_line, hit);
      end
    end
  endtask

  task automatic test_march();
    logic [19:0] exp_seq[3] = '{20'h0AAAA, 20'h15554, 20'h2AAA8};
    do_reset();
    bullet_x = 5'd31; level = 3'd3; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 1'b0;
      if (i < 3) begin
        checks++;
        if (invaders_array !== exp_seq[i] || invaders_line !== 5'd0) begin
          errors++;
          $display("FAIL march_seq %0d: arr=%h line=%0d want %h 0", i, invaders_array, invaders_line, exp_seq[i]);
        end
      end
      checks++;
      if (invaders_array !== m_arr() || invaders_line !== 5'(m_line) || hit !== m_hit) begin
        errors++;
        $display("FAIL march cyc %0d: arr=%h line=%0d hit=%b want %h %0d %b",
                 i, invaders_array, invaders_line, hit, m_arr(), m_line, m_hit);
      end
    end
    // 0x0AAAA reaches bit19 after 4 shifts; the 5th step descends without moving
    checks++;
    if (m_line < 1) begin
      errors++;
      $display("FAIL march_descent: model line=%0d want >=1", m_line);
    end
  endtask

  task automatic test_hit();
    do_reset();
    level = 3'd0; bullet_x = 5'd31; start = 1'b1;
    tick();
    start = 1'b0; bullet_x = 5'd3; bullet_y = 4'd0;
    tick();
    checks++;
    if (hit !== 1'b1 || invaders_array !== 20'h0AAA2) begin
      errors++;
      $display("FAIL hit_first: hit=%b arr=%h want 1 0aaa2", hit, invaders_array);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hit !== 1'b0 || invaders_array !== 20'h0AAA2) begin
        errors++;
        $display("FAIL hit_held %0d: hit=%b arr=%h want 0 0aaa2", i, hit, invaders_array);
      end
    end
  endtask

  task automatic test_level();
    logic [24:0] prev;
    int steps;
    do_reset();
    bullet_x = 5'd31; level = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      prev = {invaders_line, invaders_array};
      tick();
      checks++;
      if ({invaders_line, invaders_array} === prev || invaders_array !== m_arr()) begin
        errors++;
        $display("FAIL level3_step %0d: arr=%h line=%0d want %h %0d (changed)", i, invaders_array, invaders_line, m_arr(), m_line);
      end
    end
    level = 3'd1;
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      prev = {invaders_line, invaders_array};
      tick();
      if ({invaders_line, invaders_array} !== prev) steps++;
      checks++;
      if (invaders_array !== m_arr() || invaders_line !== 5'(m_line)) begin
        errors++;
        $display("FAIL level1 cyc %0d: arr=%h line=%0d want %h %0d", i, invaders_array, invaders_line, m_arr(), m_line);
      end
    end
    checks++;
    if (steps != 3) begin
      errors++;
      $display("FAIL level1_rate: steps=%0d want 3", steps);
    end
  endtask

  task automatic test_land();
    logic [19:0] frozen;
    int n;
    do_reset();
    bullet_x = 5'd31; level = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (m_run && n < 2000) begin
      tick();
      n++;
      checks++;
      if (invaders_array !== m_arr() || invaders_line !== 5'(m_line) || hit !== 1'b0) begin
        errors++;
        $display("FAIL land cyc %0d: arr=%h line=%0d hit=%b want %h %0d 0", n, invaders_array, invaders_line, hit, m_arr(), m_line);
      end
    end
    checks++;
    if (n >= 2000 || invaders_line !== 5'd16) begin
      errors++;
      $display("FAIL land_reached: line=%0d after %0d cycles want 16", invaders_line, n);
    end
    frozen = invaders_array;
    bullet_x = 5'd1; bullet_y = 4'd0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (invaders_array !== frozen || invaders_line !== 5'd16 || hit !== 1'b0) begin
      errors++;
      $display("FAIL land_frozen: arr=%h line=%0d hit=%b want %h 16 0", invaders_array, invaders_line, hit, frozen);
    end
    bullet_x = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (invaders_array !== 20'h0AAAA || invaders_line !== 5'd0) begin
      errors++;
      $display("FAIL land_restart: arr=%h line=%0d want 0aaaa 0", invaders_array, invaders_line);
    end
  endtask

  task automatic test_kill_all();
    int hits, n;
    int live[$];
    do_reset();
    level = 3'd0; bullet_x = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    hits = 0; n = 0;
    while (m_run && n < 200) begin
      live.delete();
      for (int c = 0; c < 20; c++) if (m_alive[c]) live.push_back(c);
      bullet_x = 5'(live[$urandom_range(0, live.size() - 1)]);
      bullet_y = 4'(m_line);
      tick();
      n++;
      if (hit === 1'b1) hits++;
      checks++;
      if (invaders_array !== m_arr() || invaders_line !== 5'(m_line) || hit !== m_hit) begin
        errors++;
        $display("FAIL kill cyc %0d: arr=%h line=%0d hit=%b want %h %0d %b", n, invaders_array, invaders_line, hit, m_arr(), m_line, m_hit);
      end
    end
    checks++;
    if (invaders_array !== 20'd0 || hits != 8) begin
      errors++;
      $display("FAIL kill_all: arr=%h hits=%0d want 0 8", invaders_array, hits);
    end
    bullet_x = 5'd31;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (invaders_array !== 20'd0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle: arr=%h hit=%b want 0 0", invaders_array, hit);
    end
    // Reset mid-game must clear outputs without waiting for a clock edge
    start = 1'b1; level = 3'd2;
    tick();
    start = 1'b0; bullet_x = 5'd1; bullet_y = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (invaders_array !== 20'd0 || invaders_line !== 5'd0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: arr=%h line=%0d hit=%b want 0 0 0", invaders_array, invaders_line, hit);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) level = 3'($urandom_range(0, 7));
      bullet_x = 5'($urandom_range(0, 23));
      bullet_y = 4'((m_line + $urandom_range(0, 1)) % 16);
      tick();
      checks++;
      if (invaders_array !== m_arr() || invaders_line !== 5'(m_line) || hit !== m_hit) begin
        errors++;
        $display("FAIL random cyc %0d: arr=%h line=%0d hit=%b want %h %0d %b", i, invaders_array, invaders_line, hit, m_arr(), m_line, m_hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_march();
    test_hit();
    test_level();
    test_land();
    test_kill_all();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
